// File: rtl/rom_read_sequencer_pkg.sv
// Shared definitions for the ROM read sequencer.
// FSM state encodings, default bus widths and access-timer width.
package rom_read_sequencer_pkg;

  localparam int ROM_ADDR_W_DEF = 9;
  localparam int ROM_DATA_W_DEF = 8;
  localparam int TIMER_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HAND  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  function automatic logic [TIMER_W-1:0] timer_count(
    input int cycles
  );
    return TIMER_W'(cycles);
  endfunction

endpackage

// File: rtl/rom_read_sequencer_if.sv
// ROM bus plus downstream valid/ready stream of the ROM reader.
// master: sequencer side; slave: ROM model / consumer side.
interface rom_read_sequencer_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] rom_address;
  logic                  rom_cs_n;
  logic                  rom_oe_n;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;
  logic [ADDR_WIDTH-1:0] address_line;

  modport master (
    output rom_address,
    output rom_cs_n,
    output rom_oe_n,
    input  rom_data,
    output data_out,
    output data_valid,
    input  data_ready,
    output address_line
  );

  modport slave (
    input  rom_address,
    input  rom_cs_n,
    input  rom_oe_n,
    output rom_data,
    input  data_out,
    input  data_valid,
    output data_ready,
    input  address_line
  );

endinterface

// File: rtl/rom_access_timer.sv
// Loadable down-counter timing the ROM output-enable window.
// Ports: clk, reset (async, low), load/load_val, en, expired.
module rom_access_timer
  import rom_read_sequencer_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  // expired marks the last counted clock, so a load of N
  // gives exactly N enabled clocks up to and including it.
  assign expired = (cnt == W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/rom_read_sequencer.sv
// Walks ROM addresses 0..LAST_ADDRESS and streams each word out.
// Ports: clk, reset (async, low), start, abort, bus (master),
// busy, done; checksum when ROM_SEQ_CHECKSUM_EN is defined.
module rom_read_sequencer
  import rom_read_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH    = ROM_ADDR_W_DEF,
  parameter int DATA_WIDTH    = ROM_DATA_W_DEF,
  parameter int ACCESS_CYCLES = 4,
  parameter int LAST_ADDRESS  = 511
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  rom_read_sequencer_if.master bus,
  output logic busy,
`ifdef ROM_SEQ_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  output logic done
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(LAST_ADDRESS);

  seq_state_t            state;
  logic                  start_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  cs_n;
  logic                  oe_n;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dvalid;
  logic                  t_load;
  logic                  t_en;
  logic                  t_exp;
  logic                  start_edge;
  logic                  accept;

`ifdef ROM_SEQ_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;
  assign checksum = sum;
`endif

  assign start_edge = start & ~start_q;
  assign accept     = dvalid & bus.data_ready;
  assign t_load     = (state == ST_SETUP);
  assign t_en       = (state == ST_WAIT);

  // The bus address and display address both track addr;
  // addr only moves at run start or on an accepted word.
  assign bus.rom_address  = addr;
  assign bus.address_line = addr;
  assign bus.rom_cs_n     = cs_n;
  assign bus.rom_oe_n     = oe_n;
  assign bus.data_out     = dout;
  assign bus.data_valid   = dvalid;

  rom_access_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (timer_count(ACCESS_CYCLES)),
    .en       (t_en),
    .expired  (t_exp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
      addr    <= '0;
      cs_n    <= 1'b1;
      oe_n    <= 1'b1;
      dout    <= '0;
      dvalid  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef ROM_SEQ_CHECKSUM_EN
      sum     <= '0;
`endif
    end else begin
      start_q <= start;
      if (abort) begin
        // Abort beats start and accept; addr is kept.
        state  <= ST_IDLE;
        cs_n   <= 1'b1;
        oe_n   <= 1'b1;
        dvalid <= 1'b0;
        busy   <= 1'b0;
        done   <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE, ST_DONE: begin
            if (start_edge) begin
              addr  <= '0;
              busy  <= 1'b1;
              done  <= 1'b0;
              cs_n  <= 1'b0;
              oe_n  <= 1'b1;
              state <= ST_SETUP;
`ifdef ROM_SEQ_CHECKSUM_EN
              sum   <= '0;
`endif
            end
          end
          ST_SETUP: begin
            oe_n  <= 1'b0;
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (t_exp) begin
              dout   <= bus.rom_data;
              dvalid <= 1'b1;
              cs_n   <= 1'b1;
              oe_n   <= 1'b1;
              state  <= ST_HAND;
            end
          end
          ST_HAND: begin
            if (accept) begin
              dvalid <= 1'b0;
`ifdef ROM_SEQ_CHECKSUM_EN
              sum    <= sum + dout;
`endif
              if (addr == LAST) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                addr  <= addr + ADDR_WIDTH'(1);
                cs_n  <= 1'b0;
                state <= ST_SETUP;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Randomized self-checking bench for rom_read_sequencer.
// Scoreboard of expected words plus bus-protocol monitor.
module tb_rom_read_sequencer;

  localparam int AW   = 9;
  localparam int DW   = 8;
  localparam int AC   = 4;
  localparam int LAST = 9;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;
`ifdef ROM_SEQ_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  rom_read_sequencer_if #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) bus ();

  rom_read_sequencer #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .ACCESS_CYCLES (AC),
    .LAST_ADDRESS  (LAST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
`ifdef ROM_SEQ_CHECKSUM_EN
    .checksum (checksum),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ROM model; in glitch mode the word is only correct in
  // the last oe_n-low clock before the capture edge.
  logic [DW-1:0] rom [0:511];
  bit            glitch = 1'b0;
  int            phase  = 0;

  always @(posedge clk)
    phase <= bus.rom_oe_n ? 0 : phase + 1;

  always_comb
    bus.rom_data = (glitch && phase != AC - 1)
                 ? ~rom[bus.rom_address]
                 :  rom[bus.rom_address];

  int            exp_a [$];
  logic [DW-1:0] exp_d [$];

  task automatic load_exp();
    exp_a.delete();
    exp_d.delete();
    for (int a = 0; a <= LAST; a++) begin
      exp_a.push_back(a);
      exp_d.push_back(rom[a]);
    end
  endtask

  function automatic int rom_sum();
    int s = 0;
    for (int a = 0; a <= LAST; a++) s += rom[a];
    return s % 256;
  endfunction

  logic          pv    = 1'b0;
  logic          phold = 1'b0;
  logic [DW-1:0] pd    = '0;
  int            su    = 0;
  int            oe    = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (phold) begin
        check("hold_valid", bus.data_valid, 1);
        check("hold_data", bus.data_out, pd);
      end
      if (bus.data_valid) begin
        check("hs_cs_n", bus.rom_cs_n, 1);
        check("hs_oe_n", bus.rom_oe_n, 1);
      end
      if (bus.data_valid && !pv) begin
        check("setup_clks", su, 1);
        check("oe_low_clks", oe, AC);
      end
      if (bus.data_valid && bus.data_ready && !abort) begin
        if (exp_a.size() == 0) begin
          check("extra_word", bus.address_line, 32'hffff_ffff);
        end else begin
          check("word_addr", bus.address_line, exp_a.pop_front());
          check("word_data", bus.data_out, exp_d.pop_front());
        end
      end
      if (bus.rom_cs_n) begin
        su <= 0;
        oe <= 0;
      end else if (bus.rom_oe_n) begin
        su <= su + 1;
      end else begin
        oe <= oe + 1;
      end
    end else begin
      su <= 0;
      oe <= 0;
    end
    pv    <= bus.data_valid & reset;
    phold <= bus.data_valid & ~bus.data_ready & ~abort & reset;
    pd    <= bus.data_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit rnd);
    int n = 0;
    while (!done && n < 600) begin
      if (rnd) bus.data_ready = ($urandom % 4) != 0;
      step();
      n++;
    end
    bus.data_ready = 1'b1;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_addr_line"}, bus.address_line, LAST);
    check({tag, "_words_left"}, exp_a.size(), 0);
`ifdef ROM_SEQ_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, rom_sum());
`endif
  endtask

  task automatic wait_at(input string tag, input int a, input bit want_oe);
    int n = 0;
    while (!(bus.address_line == AW'(a) &&
             (want_oe ? !bus.rom_oe_n : bus.data_valid)) && n < 200) begin
      step();
      n++;
    end
    check({tag, "_reached"}, bus.address_line, a);
  endtask

  initial begin
    int lat;
    for (int a = 0; a < 512; a++) rom[a] = DW'(a + 1);
    bus.data_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_address", bus.rom_address, 0);
    check("rst_cs_n", bus.rom_cs_n, 1);
    check("rst_oe_n", bus.rom_oe_n, 1);
    check("rst_data_out", bus.data_out, 0);
    check("rst_data_valid", bus.data_valid, 0);
    check("rst_address_line", bus.address_line, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef ROM_SEQ_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    reset = 1'b1;
    step();

    // Run 1: data = addr+1, ready held high, latency check.
    load_exp();
    start = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        check("run1_busy_at_start", busy, 1);
      end
    end while (!bus.data_valid && lat < 40);
    // One clock to see the edge, then 1+AC to the capture.
    check("first_valid_latency", lat, 2 + AC);
    wait_done("run1", 1'b0);
    repeat (3) step();
    check("done_level_held", done, 1);

    // Run 2: back-pressure for 7 clocks at address 3.
    load_exp();
    pulse_start();
`ifdef ROM_SEQ_CHECKSUM_EN
    check("checksum_cleared", checksum, 0);
`endif
    check("restart_done_low", done, 0);
    wait_at("bp", 3, 1'b0);
    bus.data_ready = 1'b0;
    repeat (7) begin
      step();
      check("bp_data", bus.data_out, 4);
      check("bp_addr_line", bus.address_line, 3);
      check("bp_cs_n", bus.rom_cs_n, 1);
    end
    bus.data_ready = 1'b1;
    wait_done("run2", 1'b0);

    // Run 3: random ROM, glitching data bus, random ready,
    // a second start pulse while busy must be ignored.
    for (int a = 0; a <= LAST; a++) rom[a] = DW'($urandom);
    glitch = 1'b1;
    load_exp();
    pulse_start();
    repeat (12) step();
    pulse_start();
    wait_done("run3", 1'b1);
    glitch = 1'b0;

    // Abort during WAIT at address 5, then restart from 0.
    load_exp();
    pulse_start();
    wait_at("ab_wait", 5, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_valid", bus.data_valid, 0);
    check("ab_cs_n", bus.rom_cs_n, 1);
    check("ab_oe_n", bus.rom_oe_n, 1);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_addr_held", bus.address_line, 5);
    exp_a.delete();
    exp_d.delete();
    repeat (3) step();
    check("ab_still_idle", busy, 0);
    load_exp();
    pulse_start();
    wait_done("run4", 1'b1);

    // Abort colliding with an accept, then with a start edge.
    load_exp();
    pulse_start();
    wait_at("ab_hs", 7, 1'b0);
    abort = 1'b1;
    step();
    check("abacc_addr_held", bus.address_line, 7);
    check("abacc_valid", bus.data_valid, 0);
    exp_a.delete();
    exp_d.delete();
    start = 1'b1;
    step();
    check("abstart_busy", busy, 0);
    check("abstart_cs_n", bus.rom_cs_n, 1);
    abort = 1'b0;
    start = 1'b0;
    step();

    // Async reset with a word pending at address 2.
    load_exp();
    pulse_start();
    wait_at("rs", 2, 1'b0);
    bus.data_ready = 1'b0;
    step();
    #2 reset = 1'b0;
    #1;
    check("ar_rom_address", bus.rom_address, 0);
    check("ar_cs_n", bus.rom_cs_n, 1);
    check("ar_oe_n", bus.rom_oe_n, 1);
    check("ar_data_out", bus.data_out, 0);
    check("ar_valid", bus.data_valid, 0);
    check("ar_address_line", bus.address_line, 0);
    check("ar_busy", busy, 0);
    exp_a.delete();
    exp_d.delete();
    step();
    reset = 1'b1;
    bus.data_ready = 1'b1;
    step();

    // Held start gives a single run.
    load_exp();
    start = 1'b1;
    wait_done("run5", 1'b0);
    repeat (20) step();
    check("held_start_done", done, 1);
    check("held_start_busy", busy, 0);
    start = 1'b0;
    step();
    load_exp();
    start = 1'b1;
    step();
    check("rearm_busy", busy, 1);
    start = 1'b0;
    wait_done("run6", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
